// File: rtl/ext_target_pipe.sv
// Immediate extension / branch-jump target unit: two-stage valid/ready pipeline.
// S1 registers the mode-extended immediate; S2 registers the final value.
module ext_target_pipe #(
    parameter int IN_W  = 26,
    parameter int OUT_W = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [IN_W-1:0]  In_Imm,
    input  logic [2:0]       In_Mode,
    input  logic [OUT_W-1:0] In_PC4,
    input  logic             Flush,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [OUT_W-1:0] Out_Data,
    output logic             Out_Err
);

    generate
        if (IN_W < 1 || IN_W > OUT_W - 2) begin : g_bad_in_w
            $error("ext_target_pipe: IN_W must lie in 1..OUT_W-2");
        end
        if ((OUT_W % 2) != 0) begin : g_bad_out_w
            $error("ext_target_pipe: OUT_W must be even");
        end
    endgenerate

    localparam logic [2:0] MODE_SIGN   = 3'd0;
    localparam logic [2:0] MODE_ZERO   = 3'd1;
    localparam logic [2:0] MODE_UPPER  = 3'd2;
    localparam logic [2:0] MODE_BRANCH = 3'd3;
    localparam logic [2:0] MODE_JUMP   = 3'd4;

    // One bit wider so the mask is well defined even when IN_W+2 == OUT_W.
    localparam logic [OUT_W:0]   LO_MASK_X = ((OUT_W+1)'(1) << (IN_W + 2)) - (OUT_W+1)'(1);
    localparam logic [OUT_W-1:0] HI_MASK   = ~LO_MASK_X[OUT_W-1:0];

    // Branch keeps the sign-extended form for the add; jump keeps the raw field.
    function automatic logic signed [OUT_W-1:0] ext_fn(input logic [IN_W-1:0] imm,
                                                       input logic [2:0]      mode);
        logic [OUT_W-1:0] zx;
        zx = {{(OUT_W-IN_W){1'b0}}, imm};
        case (mode)
            MODE_SIGN, MODE_BRANCH: ext_fn = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
            MODE_ZERO, MODE_JUMP:   ext_fn = zx;
            MODE_UPPER:             ext_fn = zx << (OUT_W / 2);
            default:                ext_fn = '0;
        endcase
    endfunction

    // Returns {err, data}.
    function automatic logic [OUT_W:0] final_fn(input logic signed [OUT_W-1:0] ext,
                                                input logic [2:0]              mode,
                                                input logic [OUT_W-1:0]        pc4);
        logic [OUT_W-1:0] data;
        logic             err;
        err  = 1'b0;
        data = '0;
        case (mode)
            MODE_SIGN, MODE_ZERO, MODE_UPPER: data = $unsigned(ext);
            MODE_BRANCH: data = pc4 + $unsigned(ext <<< 2);
            MODE_JUMP:   data = (pc4 & HI_MASK) | ($unsigned(ext) << 2);
            default:     err  = 1'b1;
        endcase
        final_fn = {err, data};
    endfunction

    logic                    vld_p1, vld_p2;
    logic signed [OUT_W-1:0] ext_p1;
    logic [2:0]              mode_p1;
    logic [OUT_W-1:0]        pc4_p1;
    logic [OUT_W-1:0]        data_p2;
    logic                    err_p2;
    logic                    ld_p1, ld_p2, in_fire;

    assign ld_p2    = !vld_p2 || Out_Ready;
    assign ld_p1    = !vld_p1 || ld_p2;
    assign In_Ready = ld_p1;
    assign in_fire  = In_Valid && ld_p1;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (Flush) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (ld_p1) vld_p1 <= in_fire;
            if (ld_p2) vld_p2 <= vld_p1;
        end
    end

    // ---- stage 1: extended immediate, mode, PC+4 ----
    always_ff @(posedge Clk) begin
        if (in_fire) begin
            ext_p1  <= ext_fn(In_Imm, In_Mode);
            mode_p1 <= In_Mode;
            pc4_p1  <= In_PC4;
        end
    end

    // ---- stage 2: final result, cleared by reset so outputs read zero ----
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            data_p2 <= '0;
            err_p2  <= 1'b0;
        end else if (ld_p2 && vld_p1) begin
            {err_p2, data_p2} <= final_fn(ext_p1, mode_p1, pc4_p1);
        end
    end

    assign Out_Valid = vld_p2;
    assign Out_Data  = data_p2;
    assign Out_Err   = err_p2;

endmodule

// File: tb/tb_ext_target_pipe.sv
// Directed plus randomized bench for ext_target_pipe, checked against an
// arithmetic reference model and an in-order scoreboard.
module tb_ext_target_pipe;

    localparam int IN_W  = 26;
    localparam int OUT_W = 32;

    logic             Clk = 1'b0;
    logic             Rst_n;
    logic             In_Valid;
    logic             In_Ready;
    logic [IN_W-1:0]  In_Imm;
    logic [2:0]       In_Mode;
    logic [OUT_W-1:0] In_PC4;
    logic             Flush;
    logic             Out_Valid;
    logic             Out_Ready;
    logic [OUT_W-1:0] Out_Data;
    logic             Out_Err;

    ext_target_pipe #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .In_Imm(In_Imm), .In_Mode(In_Mode), .In_PC4(In_PC4), .Flush(Flush),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Data(Out_Data),
        .Out_Err(Out_Err)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic             err;
        longint           acc;
    } item_t;

    item_t            sb[$];
    int               vectors     = 0;
    int               miscompares = 0;
    longint           cyc         = 0;
    logic [OUT_W-1:0] nxt_data;
    logic             nxt_err;
    bit               last_acc;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: plain integer arithmetic on the mode rules. Returns {err, data}.
    function automatic logic [OUT_W:0] model(input logic [IN_W-1:0]  imm,
                                             input logic [2:0]       mode,
                                             input logic [OUT_W-1:0] pc4);
        longint m, iv, pv, sx, d, blk, half;
        m    = longint'(1) << OUT_W;
        half = longint'(1) << (OUT_W / 2);
        blk  = longint'(1) << (IN_W + 2);
        iv   = longint'(imm);
        pv   = longint'(pc4);
        sx   = (iv >= (longint'(1) << (IN_W - 1))) ? iv - (longint'(1) << IN_W) : iv;
        case (mode)
            3'd0:    d = sx;
            3'd1:    d = iv;
            3'd2:    d = (iv % half) * half;
            3'd3:    d = pv + sx * 4;
            3'd4:    d = (pv / blk) * blk + iv * 4;
            default: return {1'b1, {OUT_W{1'b0}}};
        endcase
        d = ((d % m) + m) % m;
        return {1'b0, d[OUT_W-1:0]};
    endfunction

    task automatic chk(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Samples at the falling edge, updates the scoreboard for the coming rising edge.
    task automatic tick();
        bit exp_ov, ox, ix;
        @(negedge Clk);
        chk("in_ready", 32'(In_Ready), 32'((sb.size() < 2) || Out_Ready));
        exp_ov = (sb.size() > 0) && (sb[0].acc < cyc);
        chk("out_valid", 32'(Out_Valid), 32'(exp_ov));
        if (exp_ov && Out_Valid) begin
            chk("out_data", Out_Data, sb[0].data);
            chk("out_err", 32'(Out_Err), 32'(sb[0].err));
        end
        ox       = Out_Valid && Out_Ready;
        ix       = In_Valid && In_Ready;
        last_acc = ix && !Flush;
        if (Flush) begin
            sb.delete();
        end else begin
            if (ox && sb.size() > 0) void'(sb.pop_front());
            if (ix) sb.push_back('{nxt_data, nxt_err, cyc + 1});
        end
        @(posedge Clk);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [IN_W-1:0] imm, input logic [2:0] mode,
                        input logic [OUT_W-1:0] pc4, input logic [OUT_W-1:0] edata,
                        input logic eerr);
        int n;
        n        = 0;
        In_Valid = 1'b1;
        In_Imm   = imm;
        In_Mode  = mode;
        In_PC4   = pc4;
        nxt_data = edata;
        nxt_err  = eerr;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 20);
        if (!last_acc) begin
            vectors++;
            miscompares++;
            $error("FAIL accept_timeout: observed no accept, expected accept within 20 cycles");
        end
        In_Valid = 1'b0;
    endtask

    initial begin
        logic [OUT_W:0] r;
        Rst_n     = 1'b0;
        In_Valid  = 1'b0;
        In_Imm    = '0;
        In_Mode   = 3'd0;
        In_PC4    = '0;
        Flush     = 1'b0;
        Out_Ready = 1'b1;
        nxt_data  = '0;
        nxt_err   = 1'b0;
        #1;
        chk("rst_out_valid", 32'(Out_Valid), 32'd0);
        chk("rst_out_data", Out_Data, 32'd0);
        chk("rst_out_err", 32'(Out_Err), 32'd0);
        chk("rst_in_ready", 32'(In_Ready), 32'd1);
        repeat (2) @(posedge Clk);
        #1;
        Rst_n = 1'b1;

        // Directed values for the default 26/32 configuration.
        send(26'h2000000, 3'd0, 32'h0, 32'hFE000000, 1'b0);
        send(26'h2000000, 3'd1, 32'h0, 32'h02000000, 1'b0);
        send(26'h000ABCD, 3'd2, 32'h0, 32'hABCD0000, 1'b0);
        send(26'h3FFFFFF, 3'd3, 32'h00400010, 32'h0040000C, 1'b0);
        send(26'h0000001, 3'd3, 32'hFFFFFFFC, 32'h00000000, 1'b0);
        send(26'h0100000, 3'd4, 32'h90000004, 32'h90400000, 1'b0);
        send(26'h1234567, 3'd7, 32'h12345678, 32'h00000000, 1'b1);
        idle(4);

        // Backpressure: two accepted, third refused while the consumer stalls.
        Out_Ready = 1'b0;
        r = model(26'h0000123, 3'd0, 32'h0);
        send(26'h0000123, 3'd0, 32'h0, r[OUT_W-1:0], r[OUT_W]);
        r = model(26'h3000000, 3'd0, 32'h0);
        send(26'h3000000, 3'd0, 32'h0, r[OUT_W-1:0], r[OUT_W]);
        In_Valid = 1'b1;
        In_Imm   = 26'h0000456;
        In_Mode  = 3'd1;
        r        = model(26'h0000456, 3'd1, 32'h0);
        {nxt_err, nxt_data} = r;
        chk("bp_in_ready_drop", 32'(In_Ready), 32'd0);
        tick();
        Out_Ready = 1'b1;
        for (int i = 0; i < 10 && !last_acc; i++) tick();
        In_Valid = 1'b0;
        idle(4);

        // Flush with both stages full and a request presented.
        Out_Ready = 1'b0;
        r = model(26'h0000011, 3'd1, 32'h0);
        send(26'h0000011, 3'd1, 32'h0, r[OUT_W-1:0], r[OUT_W]);
        r = model(26'h0000022, 3'd1, 32'h0);
        send(26'h0000022, 3'd1, 32'h0, r[OUT_W-1:0], r[OUT_W]);
        In_Valid = 1'b1;
        In_Imm   = 26'h0000033;
        In_Mode  = 3'd1;
        {nxt_err, nxt_data} = model(26'h0000033, 3'd1, 32'h0);
        Flush    = 1'b1;
        tick();
        Flush     = 1'b0;
        In_Valid  = 1'b0;
        Out_Ready = 1'b1;
        chk("flush_out_valid", 32'(Out_Valid), 32'd0);
        idle(4);

        // Asynchronous reset between edges with S2 holding a result.
        Out_Ready = 1'b0;
        send(26'h2000000, 3'd0, 32'h0, 32'hFE000000, 1'b0);
        tick();
        chk("pre_rst_out_valid", 32'(Out_Valid), 32'd1);
        #1;
        Rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(Out_Valid), 32'd0);
        chk("mid_rst_out_data", Out_Data, 32'd0);
        chk("mid_rst_out_err", 32'(Out_Err), 32'd0);
        chk("mid_rst_in_ready", 32'(In_Ready), 32'd1);
        Rst_n = 1'b1;
        sb.delete();
        Out_Ready = 1'b1;
        idle(3);

        // Randomized traffic with random backpressure and occasional flush.
        for (int k = 0; k < 400; k++) begin
            In_Valid  = ($urandom_range(0, 3) != 0);
            In_Imm    = IN_W'($urandom);
            In_Mode   = 3'($urandom_range(0, 7));
            In_PC4    = $urandom;
            Out_Ready = ($urandom_range(0, 9) < 7);
            Flush     = ($urandom_range(0, 39) == 0);
            {nxt_err, nxt_data} = model(In_Imm, In_Mode, In_PC4);
            tick();
        end
        In_Valid  = 1'b0;
        Flush     = 1'b0;
        Out_Ready = 1'b1;
        idle(4);
        chk("drain_out_valid", 32'(Out_Valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
